// File: rtl/approx_pkg.sv
// rtl/approx_pkg.sv - shared widths, FSM states and result constants for approx_dispatch
package approx_pkg;

    localparam int X_W   = 16;
    localparam int NIT_W = 3;
    localparam int Y_W   = 17;

    localparam logic [Y_W-1:0] Y_TIMEOUT = 17'h1FFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/approx_fifo.sv
// rtl/approx_fifo.sv - synchronous job FIFO (power-of-two depth) with empty flag and occupancy count
module approx_fifo import approx_pkg::*; #(
    parameter int WIDTH = X_W + NIT_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/approx_dispatch.sv
// rtl/approx_dispatch.sv - job FIFO + one-in-flight dispatcher around the approximation core; watchdog via APPROX_DISPATCH_TIMEOUT_EN
module approx_dispatch import approx_pkg::*; #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [X_W-1:0]   in_x_i,
    input  logic [NIT_W-1:0] in_nit_i,
    output logic             core_start_o,
    output logic [X_W-1:0]   core_x_o,
    output logic [NIT_W-1:0] core_nit_o,
    input  logic             core_busy_i,
    input  logic             core_valid_i,
    input  logic [Y_W-1:0]   core_y_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Y_W-1:0]   out_y_o,
    output logic [X_W-1:0]   out_x_o,
    output logic             timeout_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("approx_dispatch: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
    end

    state_t                 state;
    logic                   core_valid_q;
    logic                   completion;
    logic                   wait_expired;
    logic                   fifo_empty;
    logic [CW-1:0]          fifo_count;
    logic [X_W+NIT_W-1:0]   fifo_head;

    // A full FIFO refuses pushes even when ISSUE pops in the same cycle.
    assign in_ready_o = (fifo_count != CW'(FIFO_DEPTH));
    assign completion = core_valid_i && !core_valid_q;

    approx_fifo #(
        .WIDTH (X_W + NIT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid_i && in_ready_o),
        .wdata ({in_x_i, in_nit_i}),
        .pop   (state == ST_ISSUE),
        .rdata (fifo_head),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef APPROX_DISPATCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wait_cnt;

    assign wait_expired = (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || state != ST_WAIT) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign wait_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            core_valid_q <= 1'b0;
            core_start_o <= 1'b0;
            core_x_o     <= '0;
            core_nit_o   <= '0;
            out_valid_o  <= 1'b0;
            out_y_o      <= '0;
            out_x_o      <= '0;
            timeout_o    <= 1'b0;
        end else begin
            core_valid_q <= core_valid_i;
            core_start_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty && !core_busy_i) begin
                        state                  <= ST_ISSUE;
                        core_start_o           <= 1'b1;
                        {core_x_o, core_nit_o} <= fifo_head;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A level still high from the previous job is not a completion.
                    if (completion) begin
                        state       <= ST_HOLD;
                        out_valid_o <= 1'b1;
                        out_y_o     <= core_y_i;
                        out_x_o     <= core_x_o;
                        timeout_o   <= 1'b0;
                    end else if (wait_expired) begin
                        state       <= ST_HOLD;
                        out_valid_o <= 1'b1;
                        out_y_o     <= Y_TIMEOUT;
                        out_x_o     <= core_x_o;
                        timeout_o   <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (out_ready_i) begin
                        state       <= ST_IDLE;
                        out_valid_o <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_approx_dispatch.sv
// tb/tb_approx_dispatch.sv - queue-model self-checking bench for approx_dispatch with a behavioural core
`timescale 1ns/1ps
module tb_approx_dispatch;

    localparam int DEPTH = 4;
`ifdef APPROX_DISPATCH_TIMEOUT_EN
    localparam int TMO = 64;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready_o;
    logic [15:0] in_x;
    logic [2:0]  in_nit;
    logic        core_start_o;
    logic [15:0] core_x_o;
    logic [2:0]  core_nit_o;
    logic        core_busy  = 1'b0;
    logic        core_valid = 1'b0;
    logic [16:0] core_y     = '0;
    logic        out_valid_o;
    logic        out_ready;
    logic [16:0] out_y_o;
    logic [15:0] out_x_o;
    logic        timeout_o;

    always #5 clk = ~clk;

    approx_dispatch #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready_o),
        .in_x_i       (in_x),
        .in_nit_i     (in_nit),
        .core_start_o (core_start_o),
        .core_x_o     (core_x_o),
        .core_nit_o   (core_nit_o),
        .core_busy_i  (core_busy),
        .core_valid_i (core_valid),
        .core_y_i     (core_y),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready),
        .out_y_o      (out_y_o),
        .out_x_o      (out_x_o),
        .timeout_o    (timeout_o)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [16:0] ref_y(input logic [15:0] x, input logic [2:0] n);
        return {1'b0, x} ^ {n, 14'h0000} ^ 17'h0CBBC;
    endfunction

    // Behavioural core: mode 0 pulses valid, 1 keeps valid high, 2 never answers.
    int          core_mode   = 0;
    int          core_lat    = 10;
    bit          busy_force  = 0;
    bit          kick        = 0;
    bit          core_active = 0;
    int          core_cnt    = 0;
    logic [15:0] cx;
    logic [2:0]  cn;

    always @(negedge clk) begin
        if (core_start_o === 1'b1) begin
            check("no_double_start", core_active, 0);
            core_active = 1;
            core_cnt    = core_lat;
            cx          = core_x_o;
            cn          = core_nit_o;
        end else if (core_active) begin
            if (core_cnt > 0) core_cnt--;
            else if (core_mode == 2) core_active = 0;
            else if (core_mode == 1 && core_valid) core_valid = 1'b0;
            else begin
                core_valid  = 1'b1;
                core_y      = ref_y(cx, cn);
                core_active = 0;
            end
        end else if (kick) begin
            core_valid = 1'b1;
            core_y     = 17'h12345;
            kick       = 0;
        end else if (core_mode != 1) begin
            core_valid = 1'b0;
        end
        core_busy = core_active || busy_force;
    end

    typedef struct packed {
        logic [15:0] x;
        logic [2:0]  nit;
    } job_t;

    job_t        pend_q[$];
    job_t        flight;
    bit          in_issue    = 0;
    bit          flight_wait = 0;
    bit          exp_ov      = 0;
    bit          exp_to      = 0;
    logic [16:0] exp_y       = '0;
    logic [15:0] exp_x       = '0;
    logic        prev_cv     = 1'b0;
    int          wait_cnt    = 0;
    int          done_cnt    = 0;

    // Reference model: advances on every rising edge from bench-driven inputs only.
    always @(posedge clk) begin
        if (rst) begin
            pend_q.delete();
            in_issue    = 0;
            flight_wait = 0;
            exp_ov      = 0;
            prev_cv     = 1'b0;
        end else begin
            if (exp_ov && out_ready) begin
                exp_ov = 0;
                done_cnt++;
            end else if (flight_wait) begin
                wait_cnt++;
                if (core_valid && !prev_cv) begin
                    exp_ov = 1; exp_to = 0; flight_wait = 0;
                    exp_y  = ref_y(flight.x, flight.nit);
                    exp_x  = flight.x;
                end
`ifdef APPROX_DISPATCH_TIMEOUT_EN
                else if (wait_cnt >= TMO) begin
                    exp_ov = 1; exp_to = 1; flight_wait = 0;
                    exp_y  = 17'h1FFFF;
                    exp_x  = flight.x;
                end
`endif
            end
            if (in_valid && (pend_q.size() + int'(in_issue)) < DEPTH)
                pend_q.push_back({in_x, in_nit});
            if (in_issue) begin
                flight_wait = 1;
                wait_cnt    = 0;
                in_issue    = 0;
            end
            prev_cv = core_valid;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", in_ready_o, (pend_q.size() + int'(in_issue)) < DEPTH);
            check("out_valid", out_valid_o, exp_ov);
            if (exp_ov) begin
                check("out_y", out_y_o, exp_y);
                check("out_x", out_x_o, exp_x);
                check("timeout", timeout_o, exp_to);
            end
            if (core_start_o === 1'b1) begin
                check("start_one_in_flight", exp_ov || flight_wait || in_issue, 0);
                check("start_has_job", pend_q.size() > 0, 1);
                if (pend_q.size() > 0) begin
                    check("core_x", core_x_o, pend_q[0].x);
                    check("core_nit", core_nit_o, pend_q[0].nit);
                    flight   = pend_q.pop_front();
                    in_issue = 1;
                end
            end
        end
    end

    task automatic push(input logic [15:0] x, input logic [2:0] n);
        int t = 0;
        in_valid = 1'b1; in_x = x; in_nit = n;
        while (in_ready_o !== 1'b1 && t < 300) begin @(negedge clk); t++; end
        check("push_bound", t < 300, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int lim);
        int t = 0;
        while (out_valid_o !== 1'b1 && t < lim) begin @(negedge clk); t++; end
        check("wait_out_bound", t < lim, 1);
    endtask

    task automatic wait_done(input int target, input int lim);
        int t = 0;
        while (done_cnt < target && t < lim) begin @(negedge clk); t++; end
        check("drain_bound", done_cnt >= target, 1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, in_ready_o, 1);
        check({tag, "_start"}, core_start_o, 0);
        check({tag, "_core_x"}, core_x_o, 0);
        check({tag, "_core_nit"}, core_nit_o, 0);
        check({tag, "_out_valid"}, out_valid_o, 0);
        check({tag, "_out_y"}, out_y_o, 0);
        check({tag, "_out_x"}, out_x_o, 0);
        check({tag, "_timeout"}, timeout_o, 0);
    endtask

    logic [15:0] bx [6] = '{16'h8001, 16'h7FFF, 16'h0000, 16'hFFFF, 16'h1234, 16'hA5A5};
    logic [2:0]  bn [6] = '{3'd0, 3'd7, 3'd1, 3'd2, 3'd5, 3'd3};
    int base;
    int t;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_x = '0; in_nit = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1;
        check_reset_state("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single job, core answers after 10 cycles.
        core_lat = 10;
        push(16'h0100, 3'd3);
        @(negedge clk);
        check("t1_start", core_start_o, 1);
        check("t1_core_x", core_x_o, 16'h0100);
        check("t1_core_nit", core_nit_o, 3'd3);
        wait_out(50);
        check("t1_out_y", out_y_o, 17'h00ABC);
        check("t1_out_x", out_x_o, 16'h0100);
        check("t1_timeout", timeout_o, 0);
        @(negedge clk);
        check("t1_out_valid_low", out_valid_o, 0);

        // Burst of six: core held busy so four fill the FIFO.
        base = done_cnt;
        core_lat = 3; busy_force = 1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) push(bx[i], bn[i]);
        check("t2_full_ready", in_ready_o, 0);
        check("t2_busy_no_start", core_start_o, 0);
        busy_force = 0;
        push(bx[4], bn[4]);
        push(bx[5], bn[5]);
        wait_done(base + 6, 400);

        // Output back-pressure for 20 cycles.
        base = done_cnt;
        out_ready = 1'b0; core_lat = 4;
        push(16'h0042, 3'd1);
        push(16'h0043, 3'd2);
        wait_out(100);
        repeat (20) begin
            @(negedge clk);
            check("t3_hold_valid", out_valid_o, 1);
            check("t3_hold_no_start", core_start_o, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("t3_hs_valid_low", out_valid_o, 0);
        check("t3_idle_no_start", core_start_o, 0);
        @(negedge clk);
        check("t3_restart", core_start_o, 1);
        check("t3_restart_x", core_x_o, 16'h0043);
        wait_done(base + 2, 100);

        // Core valid level held high across two jobs.
        base = done_cnt;
        core_mode = 1; core_lat = 3;
        push(16'h0101, 3'd4);
        push(16'h0202, 3'd6);
        wait_done(base + 2, 200);
        core_mode = 0;
        repeat (3) @(negedge clk);

        // Core never answers, then reset mid-WAIT with two jobs queued.
        core_mode = 2; core_lat = 2;
        push(16'h0777, 3'd5);
`ifdef APPROX_DISPATCH_TIMEOUT_EN
        @(negedge clk);
        check("t5_start", core_start_o, 1);
        t = 0;
        while (out_valid_o !== 1'b1 && t < 200) begin @(negedge clk); t++; end
        check("t5_timeout_latency", t, 65);
        check("t5_out_y", out_y_o, 17'h1FFFF);
        check("t5_out_x", out_x_o, 16'h0777);
        check("t5_timeout", timeout_o, 1);
        @(negedge clk);
        push(16'h0888, 3'd6);
`else
        repeat (100) @(negedge clk);
        check("t5_stays_waiting", out_valid_o, 0);
`endif
        repeat (5) @(negedge clk);
        push(16'h0999, 3'd1);
        push(16'h0AAA, 3'd2);
        check("t6_queued_no_start", core_start_o, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("t6");
        kick = 1;
        repeat (15) begin
            @(negedge clk);
            check("t6_late_edge_no_out", out_valid_o, 0);
            check("t6_fifo_flushed", core_start_o, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

endmodule
